// File: rtl/parking_pkg.sv
// Shared types and defaults for the car-park gate controller.
package parking_pkg;

  localparam int unsigned NUM_SLOTS_DEF     = 15;
  localparam int unsigned CNT_W_DEF         = 4;
  localparam int unsigned GATE_OPEN_CYC_DEF = 8;
  localparam int unsigned STAT_W            = 16;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ENTRY_OPEN = 2'd1,
    EXIT_OPEN  = 2'd2,
    COOLDOWN   = 2'd3
  } gate_state_t;

  typedef enum logic {
    PRIO_ENTRY = 1'b0,
    PRIO_EXIT  = 1'b1
  } prio_t;

endpackage

// File: rtl/slot_alloc.sv
// Combinational lowest-free-slot finder and free-slot count for the car park.
module slot_alloc
  import parking_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = NUM_SLOTS_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF
) (
  input  logic [NUM_SLOTS-1:0] slot_occ,
  input  logic [NUM_SLOTS-1:0] reserved,
  output logic [CNT_W-1:0]     idx,
  output logic                 any_free,
  output logic [CNT_W-1:0]     free_cnt_next
);

  logic [NUM_SLOTS-1:0] busy;
  logic [CNT_W-1:0]     used;

  assign busy = slot_occ | reserved;

  // Scan from the top so the lowest free index is the last one written.
  always_comb begin
    idx      = '0;
    any_free = 1'b0;
    used     = '0;
    for (int i = int'(NUM_SLOTS) - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        idx      = CNT_W'(i);
        any_free = 1'b1;
      end else begin
        used = used + CNT_W'(1);
      end
    end
  end

  assign free_cnt_next = CNT_W'(NUM_SLOTS) - used;

endmodule

// File: rtl/parking_gate_ctrl.sv
// Entry/exit barrier sequencer with slot allocation for the car park.
// Optional counters of admitted and refused cars under PARK_STATS_EN.
module parking_gate_ctrl
  import parking_pkg::*;
#(
  parameter int unsigned NUM_SLOTS     = NUM_SLOTS_DEF,
  parameter int unsigned CNT_W         = CNT_W_DEF,
  parameter int unsigned GATE_OPEN_CYC = GATE_OPEN_CYC_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_SLOTS-1:0] slot_occ,
  input  logic                 entry_req,
  input  logic                 exit_req,
  output logic                 entry_ack,
  output logic                 entry_deny,
  output logic                 exit_ack,
  output logic [CNT_W-1:0]     slot_id,
  output logic                 gate_in_open,
  output logic                 gate_out_open,
  output logic [CNT_W-1:0]     free_cnt,
  output logic                 full
`ifdef PARK_STATS_EN
  ,
  output logic [STAT_W-1:0]    stat_entries,
  output logic [STAT_W-1:0]    stat_denied
`endif
);

  localparam int unsigned TMR_W = $clog2(GATE_OPEN_CYC + 1);

  gate_state_t          state_q, state_d;
  prio_t                prio_q, prio_d;
  logic [TMR_W-1:0]     tmr_q, tmr_d;
  logic [NUM_SLOTS-1:0] reserved_q, reserved_d;
  logic [CNT_W-1:0]     slot_id_q, slot_id_d;
  logic                 entry_ack_q, entry_ack_d;
  logic                 entry_deny_q, entry_deny_d;
  logic                 exit_ack_q, exit_ack_d;
  logic                 gate_in_q, gate_in_d;
  logic                 gate_out_q, gate_out_d;
  logic [CNT_W-1:0]     free_cnt_q;
  logic                 full_q;

  logic [CNT_W-1:0]     alloc_idx;
  logic                 alloc_any;
  logic [CNT_W-1:0]     free_cnt_next;

  logic                 entry_live;
  logic                 both_req;
  logic                 admit;
  logic                 refuse;
  logic                 serve_exit;

  slot_alloc #(
    .NUM_SLOTS (NUM_SLOTS),
    .CNT_W     (CNT_W)
  ) u_slot_alloc (
    .slot_occ      (slot_occ),
    .reserved      (reserved_q),
    .idx           (alloc_idx),
    .any_free      (alloc_any),
    .free_cnt_next (free_cnt_next)
  );

  // A request denied last cycle sits out one cycle so the driver can withdraw it.
  assign entry_live = entry_req && !entry_deny_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    both_req   = 1'b0;
    admit      = 1'b0;
    refuse     = 1'b0;
    serve_exit = 1'b0;
    unique case (state_q)
      IDLE: begin
        both_req = entry_live && exit_req;
        if (entry_live && (!exit_req || prio_q == PRIO_ENTRY)) begin
          admit  = !full_q && alloc_any;
          refuse = !admit;
        end else if (exit_req) begin
          serve_exit = 1'b1;
        end
        if (admit) begin
          state_d = ENTRY_OPEN;
        end else if (serve_exit) begin
          state_d = EXIT_OPEN;
        end
      end
      ENTRY_OPEN, EXIT_OPEN: begin
        if (tmr_q == '0) begin
          state_d = COOLDOWN;
        end
      end
      COOLDOWN: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Gate drive lags the ack by one edge and drops before COOLDOWN begins.
  always_comb begin
    prio_d       = prio_q;
    tmr_d        = tmr_q;
    reserved_d   = reserved_q & ~slot_occ;
    slot_id_d    = slot_id_q;
    entry_ack_d  = 1'b0;
    entry_deny_d = refuse;
    exit_ack_d   = 1'b0;
    gate_in_d    = (state_q == ENTRY_OPEN) && (tmr_q != '0);
    gate_out_d   = (state_q == EXIT_OPEN) && (tmr_q != '0);
    if ((state_q == ENTRY_OPEN || state_q == EXIT_OPEN) && tmr_q != '0) begin
      tmr_d = tmr_q - TMR_W'(1);
    end
    if (admit) begin
      reserved_d[alloc_idx] = 1'b1;
      slot_id_d             = alloc_idx;
      entry_ack_d           = 1'b1;
      tmr_d                 = TMR_W'(GATE_OPEN_CYC);
    end
    if (serve_exit) begin
      exit_ack_d = 1'b1;
      tmr_d      = TMR_W'(GATE_OPEN_CYC);
    end
    if (both_req && (admit || serve_exit)) begin
      prio_d = (prio_q == PRIO_ENTRY) ? PRIO_EXIT : PRIO_ENTRY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q       <= PRIO_ENTRY;
      tmr_q        <= '0;
      reserved_q   <= '0;
      slot_id_q    <= '0;
      entry_ack_q  <= 1'b0;
      entry_deny_q <= 1'b0;
      exit_ack_q   <= 1'b0;
      gate_in_q    <= 1'b0;
      gate_out_q   <= 1'b0;
      free_cnt_q   <= CNT_W'(NUM_SLOTS);
      full_q       <= 1'b0;
    end else begin
      prio_q       <= prio_d;
      tmr_q        <= tmr_d;
      reserved_q   <= reserved_d;
      slot_id_q    <= slot_id_d;
      entry_ack_q  <= entry_ack_d;
      entry_deny_q <= entry_deny_d;
      exit_ack_q   <= exit_ack_d;
      gate_in_q    <= gate_in_d;
      gate_out_q   <= gate_out_d;
      free_cnt_q   <= free_cnt_next;
      full_q       <= (free_cnt_next == '0);
    end
  end

  assign entry_ack     = entry_ack_q;
  assign entry_deny    = entry_deny_q;
  assign exit_ack      = exit_ack_q;
  assign slot_id       = slot_id_q;
  assign gate_in_open  = gate_in_q;
  assign gate_out_open = gate_out_q;
  assign free_cnt      = free_cnt_q;
  assign full          = full_q;

`ifdef PARK_STATS_EN
  logic [STAT_W-1:0] stat_ent_q, stat_den_q;

  // Saturating event counters, updated on the same edge as the pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_ent_q <= '0;
      stat_den_q <= '0;
    end else begin
      if (entry_ack_d && stat_ent_q != '1) begin
        stat_ent_q <= stat_ent_q + STAT_W'(1);
      end
      if (entry_deny_d && stat_den_q != '1) begin
        stat_den_q <= stat_den_q + STAT_W'(1);
      end
    end
  end

  assign stat_entries = stat_ent_q;
  assign stat_denied  = stat_den_q;
`endif

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Randomized bench for parking_gate_ctrl against a timestamp-based reference model.
module tb_parking_gate_ctrl;

  localparam int NS  = 15;
  localparam int CW  = 4;
  localparam int GOC = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NS-1:0] slot_occ;
  logic          entry_req, exit_req;
  logic          entry_ack, entry_deny, exit_ack;
  logic [CW-1:0] slot_id, free_cnt;
  logic          gate_in_open, gate_out_open, full;
`ifdef PARK_STATS_EN
  logic [15:0]   stat_entries, stat_denied;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: cycle index, time from which decisions are taken, gate windows.
  int            cyc;
  int            idle_from;
  bit            prio_exit;
  logic [NS-1:0] m_resv;
  bit            m_ack, m_deny, m_xack, m_full;
  int            m_slot, m_free;
  int            gin_lo, gin_hi, gout_lo, gout_hi;
  int            m_st_ent, m_st_den;
  bit            hold_on_deny;

  always #5 clk = ~clk;

  parking_gate_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .slot_occ      (slot_occ),
    .entry_req     (entry_req),
    .exit_req      (exit_req),
    .entry_ack     (entry_ack),
    .entry_deny    (entry_deny),
    .exit_ack      (exit_ack),
    .slot_id       (slot_id),
    .gate_in_open  (gate_in_open),
    .gate_out_open (gate_out_open),
    .free_cnt      (free_cnt),
    .full          (full)
`ifdef PARK_STATS_EN
    ,
    .stat_entries  (stat_entries),
    .stat_denied   (stat_denied)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    idle_from = 0;
    prio_exit = 1'b0;
    m_resv    = '0;
    m_ack     = 1'b0;
    m_deny    = 1'b0;
    m_xack    = 1'b0;
    m_full    = 1'b0;
    m_slot    = 0;
    m_free    = NS;
    gin_lo    = 1;
    gin_hi    = 0;
    gout_lo   = 1;
    gout_hi   = 0;
    m_st_ent  = 0;
    m_st_den  = 0;
  endtask

  // Advance the model across one clock edge using the inputs presently applied.
  task automatic model_step();
    logic [NS-1:0] busy;
    int  lowest;
    bit  live, take_entry, take_exit, n_ack, n_deny, n_xack;
    busy   = slot_occ | m_resv;
    lowest = -1;
    for (int i = NS - 1; i >= 0; i--) if (!busy[i]) lowest = i;
    live   = entry_req && !m_deny;
    n_ack  = 1'b0;
    n_deny = 1'b0;
    n_xack = 1'b0;
    m_resv = m_resv & ~slot_occ;
    if (cyc >= idle_from) begin
      take_entry = live && (!exit_req || !prio_exit);
      take_exit  = exit_req && (!live || prio_exit);
      if (take_entry && (m_full || lowest < 0)) begin
        n_deny = 1'b1;
      end else if (take_entry) begin
        n_ack          = 1'b1;
        m_resv[lowest] = 1'b1;
        m_slot         = lowest;
        gin_lo         = cyc + 2;
        gin_hi         = cyc + 1 + GOC;
        idle_from      = cyc + GOC + 3;
      end else if (take_exit) begin
        n_xack    = 1'b1;
        gout_lo   = cyc + 2;
        gout_hi   = cyc + 1 + GOC;
        idle_from = cyc + GOC + 3;
      end
      if (live && exit_req && !n_deny) prio_exit = !prio_exit;
    end
    if (n_ack && m_st_ent < 65535) m_st_ent++;
    if (n_deny && m_st_den < 65535) m_st_den++;
    m_ack  = n_ack;
    m_deny = n_deny;
    m_xack = n_xack;
    m_free = NS - $countones(busy);
    m_full = (m_free == 0);
    cyc++;
  endtask

  task automatic tick();
    bit gin_exp, gout_exp;
    model_step();
    @(posedge clk);
    #1;
    gin_exp  = (cyc >= gin_lo) && (cyc <= gin_hi);
    gout_exp = (cyc >= gout_lo) && (cyc <= gout_hi);
    check("entry_ack", entry_ack, m_ack);
    check("entry_deny", entry_deny, m_deny);
    check("exit_ack", exit_ack, m_xack);
    check("slot_id", slot_id, m_slot);
    check("gate_in_open", gate_in_open, gin_exp);
    check("gate_out_open", gate_out_open, gout_exp);
    check("gate_overlap", gate_in_open & gate_out_open, 0);
    check("free_cnt", free_cnt, m_free);
    check("full", full, m_full);
`ifdef PARK_STATS_EN
    check("stat_entries", stat_entries, m_st_ent);
    check("stat_denied", stat_denied, m_st_den);
`endif
    @(negedge clk);
    if (m_ack) entry_req = 1'b0;
    if (m_deny && !hold_on_deny) entry_req = 1'b0;
    if (m_xack) exit_req = 1'b0;
  endtask

  // Called at a falling edge; the gates must close without waiting for a clock.
  task automatic do_reset(input int cycles);
    rst_n     = 1'b0;
    entry_req = 1'b0;
    exit_req  = 1'b0;
    #1;
    check("rst_gate_in", gate_in_open, 0);
    check("rst_gate_out", gate_out_open, 0);
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    check("rst_entry_ack", entry_ack, 0);
    check("rst_entry_deny", entry_deny, 0);
    check("rst_exit_ack", exit_ack, 0);
    check("rst_slot_id", slot_id, 0);
    check("rst_free_cnt", free_cnt, NS);
    check("rst_full", full, 0);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int r;
    rst_n        = 1'b1;
    slot_occ     = '0;
    entry_req    = 1'b0;
    exit_req     = 1'b0;
    hold_on_deny = 1'b0;
    cyc          = 0;
    model_reset();
    @(negedge clk);
    do_reset(2);

    // Single entry into an empty park.
    entry_req = 1'b1;
    repeat (12) tick();
    check("tp1_slot", slot_id, 0);
    check("tp1_free", free_cnt, 14);

    // Only slot 0 free; the car then arrives on its sensor.
    do_reset(1);
    slot_occ  = 15'h7FFE;
    entry_req = 1'b1;
    repeat (12) tick();
    check("tp2_slot", slot_id, 0);
    slot_occ = 15'h7FFF;
    repeat (3) tick();
    check("tp2_free", free_cnt, 0);
    check("tp2_full", full, 1);

    // Park full with the request held: repeated denials, no gate.
    do_reset(1);
    hold_on_deny = 1'b1;
    entry_req    = 1'b1;
    repeat (7) tick();
    check("tp3_gate_in", gate_in_open, 0);
    hold_on_deny = 1'b0;
    entry_req    = 1'b0;
    tick();

    // Simultaneous requests alternate priority.
    do_reset(1);
    slot_occ  = '0;
    entry_req = 1'b1;
    exit_req  = 1'b1;
    repeat (26) tick();
    entry_req = 1'b1;
    exit_req  = 1'b1;
    repeat (26) tick();

    // Back-to-back entries without sensor updates.
    do_reset(1);
    entry_req = 1'b1;
    repeat (12) tick();
    entry_req = 1'b1;
    repeat (12) tick();
    check("tp5_slot", slot_id, 1);
    check("tp5_free", free_cnt, 13);

    // Reset in the middle of an open entry gate.
    do_reset(1);
    entry_req = 1'b1;
    repeat (4) tick();
    check("tp6_gate_before", gate_in_open, 1);
    do_reset(1);
    repeat (2) tick();
    check("tp6_free", free_cnt, 15);

    // Random traffic with parking, leaving and flapping sensors.
    for (int c = 0; c < 1500; c++) begin
      if (c == 750) do_reset(1);
      hold_on_deny = ($urandom_range(0, 1) == 1);
      if (!entry_req && $urandom_range(0, 5) == 0) entry_req = 1'b1;
      if (!exit_req && $urandom_range(0, 6) == 0) exit_req = 1'b1;
      r = int'($urandom_range(0, 31));
      if (r < 3 && m_resv != '0) begin
        for (int i = 0; i < NS; i++) begin
          if (m_resv[i] && !slot_occ[i]) begin
            slot_occ[i] = 1'b1;
            break;
          end
        end
      end else if (r == 3) begin
        slot_occ[$urandom_range(0, NS - 1)] = 1'b0;
      end else if (r == 4) begin
        r = int'($urandom_range(0, NS - 1));
        slot_occ[r] = ~slot_occ[r];
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/parking_gate_ctrl.md
Name: parking_gate_ctrl

Overview:
- Sequences the entry and exit barrier gates of the 15-slot car park.
- Arbitrates between entry and exit requests and allocates a free slot to each admitted car.
- Tracks reserved slots and publishes a registered free-slot count and full flag for the display.
- Consumes the per-slot occupancy sensor vector directly.

Parameters:
- NUM_SLOTS, 15: number of parking slots and sensor bits.
- CNT_W, 4: width of the slot index and the count. Must satisfy 2^CNT_W > NUM_SLOTS.
- GATE_OPEN_CYC, 8: cycles a gate stays open per admitted car. Must be ≥1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- slot_occ  in  NUM_SLOTS  per-slot sensor; 1 = car present. Already synchronous to clk.
- entry_req  in  1  car waiting at entry. Level, held until entry_ack or entry_deny.
- exit_req  in  1  car waiting at exit. Level, held until exit_ack.
- entry_ack  out  1  one-cycle pulse: entry gate opening, slot_id valid.
- entry_deny  out  1  one-cycle pulse: park full, entry refused.
- exit_ack  out  1  one-cycle pulse: exit gate opening.
- slot_id  out  CNT_W  allocated slot index. Held from entry_ack until the next allocation.
- gate_in_open  out  1  entry barrier drive.
- gate_out_open  out  1  exit barrier drive.
- free_cnt  out  CNT_W  registered count of slots neither occupied nor reserved.
- full  out  1  registered; 1 when free_cnt == 0.

Behaviour:
- Reset values: all outputs 0 except free_cnt = NUM_SLOTS. reserved mask = 0, state = IDLE, prio = ENTRY.
- free_cnt = NUM_SLOTS − popcount(slot_occ | reserved). Registered, 1-cycle latency. Unsigned, never wraps.
- FSM states: IDLE, ENTRY_OPEN, EXIT_OPEN, COOLDOWN.
- IDLE, only one request set: serve that request.
- IDLE, both requests set: serve the side named by prio, then toggle prio to the other side (alternating).
- IDLE, no requests: stay in IDLE.
- Entry serve when full==1: entry_deny pulses for 1 cycle, FSM stays IDLE, prio is unchanged.
  - A held entry_req is re-evaluated every IDLE cycle. Deny can therefore repeat every 2 cycles while the request persists (deny, then request drop or re-check).
- Entry serve when not full:
  - Choose the lowest index i with slot_occ[i]==0 and reserved[i]==0.
  - Set reserved[i], load slot_id = i, pulse entry_ack.
  - Go to ENTRY_OPEN, gate_in_open = 1 for GATE_OPEN_CYC cycles.
- Exit serve: pulse exit_ack, go to EXIT_OPEN, gate_out_open = 1 for GATE_OPEN_CYC cycles.
- Gate timing: ack is asserted in the same cycle as the transition into the OPEN state. The gate output rises on the next edge.
- After the open count expires: COOLDOWN for 1 cycle with both gates closed, then IDLE. Gates are never open simultaneously.
- Reserved-bit clearing:
  - reserved[i] clears on the cycle slot_occ[i] is seen as 1.
  - A set and a clear of the same bit in one cycle resolve to the set.
- Requests arriving while the FSM is busy are not lost (level-held). They are served from IDLE after COOLDOWN.
- Sensor flapping on an occupied slot only changes free_cnt. It does not touch the FSM.
- Asynchronous reset mid-operation closes both gates immediately, clears reserved, and returns to IDLE.

Optional Feature:
- Macro: PARK_STATS_EN.
- Defined:
  - Adds outputs stat_entries[15:0] and stat_denied[15:0].
  - stat_entries increments on entry_ack; stat_denied increments on entry_deny.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package parking_pkg holds:
  - NUM_SLOTS and CNT_W defaults.
  - FSM state enum gate_state_t.
  - Priority enum prio_t {PRIO_ENTRY, PRIO_EXIT}.
- One sub-module, slot_alloc: combinational lowest-free-index finder plus popcount.
  - Inputs: slot_occ, reserved.
  - Outputs: idx, any_free, free_cnt_next.

Test Plan:
- Reset, then entry_req with slot_occ = 0 → entry_ack after 1 cycle, slot_id = 0, gate_in_open high for 8 cycles, free_cnt 15 → 14.
- slot_occ = 15'h7FFE, entry_req → slot_id = 0. Then set slot_occ[0] → reserved clears, free_cnt = 0, full = 1.
- slot_occ = 15'h7FFF, entry_req held → entry_deny pulse, no gate opens, free_cnt = 0. With PARK_STATS_EN, stat_denied increments.
- entry_req and exit_req both raised in the same cycle from reset → entry served first. Exit is acked 1 cycle after COOLDOWN, gates never overlap. A second simultaneous pair is served exit first.
- Two entries back to back with slot_occ = 0 and no sensor update → slot_id 0 then 1, free_cnt = 13.
- rst_n driven low during ENTRY_OPEN cycle 3 → gate_in_open drops asynchronously, free_cnt returns to 15 after release.
